// File: rtl/virtio_descriptor_request_pkg.sv
// Shared types and constants for the virtio descriptor request block.
// Contents: configuration FSM states, descriptor/config sizes, the
// outgoing request layout and the descriptor address helper.
package virtio_descriptor_request_pkg;

    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        LOAD   = 2'd1,
        READY  = 2'd2
    } cfg_state_t;

    // One split-ring descriptor is 16 bytes; every read fetches exactly one.
    localparam logic [31:0] DESC_SIZE     = 32'd16;
    // Config packet: base[63:0] LE in bytes 0-7, qsize[15:0] LE in bytes 8-9.
    localparam logic [3:0]  CFG_BYTES     = 4'd10;
    localparam logic [3:0]  CFG_LAST_BYTE = CFG_BYTES - 4'd1;

    typedef struct packed {
        logic [31:0] len;
        logic [63:0] addr;
    } request_t;

    // Descriptor table entry address; the add wraps modulo 2^64.
    function automatic logic [63:0] desc_addr(input logic [63:0] base,
                                              input logic [15:0] idx);
        return base + {44'd0, idx, 4'd0};
    endfunction

endpackage

// File: rtl/virtio_descriptor_request_tags.sv
// Read-tag allocator: busy bitmap, lowest-free priority encoder and an
// outstanding counter.
// Ports:
//   clk_i/rst_i      clock, async active-high reset
//   alloc_i          allocate alloc_tag_i this cycle (always a free tag)
//   done_i/done_tag_i completion; frees the tag if busy, else flags done_err_o
//   free_tag_o       lowest free tag (from registered bitmap only)
//   free_avail_o     at least one tag free (no combinational path from done_i)
//   empty_o          no tags outstanding
//   done_err_o       completion addressed a free or nonexistent tag
module virtio_descriptor_request_tags #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int TAG_WIDTH       = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alloc_i,
    input  logic [TAG_WIDTH-1:0] alloc_tag_i,
    input  logic                 done_i,
    input  logic [TAG_WIDTH-1:0] done_tag_i,
    output logic [TAG_WIDTH-1:0] free_tag_o,
    output logic                 free_avail_o,
    output logic                 empty_o,
    output logic                 done_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TAG_WIDTH:0] LAST_TAG = (TAG_WIDTH + 1)'(MAX_OUTSTANDING - 1);

    logic [MAX_OUTSTANDING-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       done_hit_s;

    // Lowest free tag: scan downwards so the lowest free index is written last.
    always_comb begin
        free_tag_o   = '0;
        free_avail_o = 1'b0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            free_tag_o   = busy_q[i] ? free_tag_o : TAG_WIDTH'(i);
            free_avail_o = free_avail_o | ~busy_q[i];
        end
    end

    // Bitmap and counter next state; alloc and done in one cycle both apply.
    always_comb begin
        busy_d     = busy_q;
        count_d    = count_q;
        done_hit_s = 1'b0;
        done_err_o = 1'b0;
        if (done_i) begin
            if (({1'b0, done_tag_i} <= LAST_TAG) && busy_q[done_tag_i]) begin
                busy_d[done_tag_i] = 1'b0;
                done_hit_s         = 1'b1;
            end else begin
                done_err_o = 1'b1;
            end
        end else begin
            done_hit_s = 1'b0;
        end
        if (alloc_i) begin
            busy_d[alloc_tag_i] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        case ({alloc_i, done_hit_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Tag state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign empty_o = (count_q == '0);

endmodule

// File: rtl/virtio_descriptor_request.sv
// Turns descriptor head indices into 16-byte descriptor-table read requests
// (addr = base + 16*idx), tags each read and frees tags on completion.
// Ports:
//   aclk/areset          clock, async active-high reset
//   configure_*          byte stream carrying base[63:0] and qsize[15:0] (LE)
//   rx_*                 descriptor head indices from the available ring
//   tx_*                 read requests {len, addr} with tag tx_tid
//   done_tvalid/done_tid completions, always accepted
//   configured           a valid configuration is loaded
//   error                1-cycle pulse: bad index, bad config, or stray completion
module virtio_descriptor_request
    import virtio_descriptor_request_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int TAG_WIDTH       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 configure_tvalid,
    input  logic [7:0]           configure_tdata,
    input  logic                 configure_tlast,
    output logic                 configure_tready,
    input  logic                 rx_tvalid,
    input  logic [15:0]          rx_tdata,
    output logic                 rx_tready,
    output logic                 tx_tvalid,
    output logic [95:0]          tx_tdata,
    output logic [TAG_WIDTH-1:0] tx_tid,
    input  logic                 tx_tready,
    input  logic                 done_tvalid,
    input  logic [TAG_WIDTH-1:0] done_tid,
    output logic                 configured,
    output logic                 error
);

    cfg_state_t           cfg_state_q, cfg_state_d;
    logic [3:0]           cfg_cnt_q, cfg_cnt_d;
    logic                 cfg_bad_q, cfg_bad_d;
    logic [71:0]          shadow_q, shadow_d;
    logic [63:0]          base_q, base_d;
    logic [15:0]          qsize_q, qsize_d;
    logic                 configured_q, configured_d;
    logic                 error_q, error_d;
    logic                 tx_valid_q, tx_valid_d;
    request_t             tx_req_q, tx_req_d;
    logic [TAG_WIDTH-1:0] tx_tid_q, tx_tid_d;

    logic                 cfg_fire_s, cfg_busy_s, cfg_err_s;
    logic [15:0]          new_qsize_s;
    logic                 rx_fire_s, idx_ok_s, alloc_s, idx_err_s;
    logic [TAG_WIDTH-1:0] free_tag_s;
    logic                 free_avail_s, tags_empty_s, done_err_s;

    virtio_descriptor_request_tags #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .TAG_WIDTH       (TAG_WIDTH)
    ) u_tags (
        .clk_i        (aclk),
        .rst_i        (areset),
        .alloc_i      (alloc_s),
        .alloc_tag_i  (free_tag_s),
        .done_i       (done_tvalid),
        .done_tag_i   (done_tid),
        .free_tag_o   (free_tag_s),
        .free_avail_o (free_avail_s),
        .empty_o      (tags_empty_s),
        .done_err_o   (done_err_s)
    );

    // Config is only taken when nothing is in flight, so base/qsize never change under a read.
    assign configure_tready = tags_empty_s && !tx_valid_q;
    assign cfg_fire_s       = configure_tvalid && configure_tready;
    // A config byte on the wire blocks new indices so they never pair with a half-loaded base.
    assign cfg_busy_s       = (cfg_state_q == LOAD) || configure_tvalid;
    assign rx_tready        = configured_q && !cfg_busy_s && free_avail_s &&
                              (!tx_valid_q || tx_tready);
    assign rx_fire_s        = rx_tvalid && rx_tready;
    assign idx_ok_s         = (rx_tdata < qsize_q);
    assign alloc_s          = rx_fire_s && idx_ok_s;
    // qsize high byte is the byte currently on the bus when the packet closes.
    assign new_qsize_s      = {configure_tdata, shadow_q[71:64]};

    // Config FSM next state: shadow fill, commit, and malformed-packet recovery.
    always_comb begin
        cfg_state_d  = cfg_state_q;
        cfg_cnt_d    = cfg_cnt_q;
        cfg_bad_d    = cfg_bad_q;
        shadow_d     = shadow_q;
        base_d       = base_q;
        qsize_d      = qsize_q;
        configured_d = configured_q;
        cfg_err_s    = 1'b0;
        if (cfg_fire_s) begin
            if (cfg_cnt_q != CFG_LAST_BYTE) begin
                shadow_d[{cfg_cnt_q, 3'b000} +: 8] = configure_tdata;
            end else begin
                shadow_d = shadow_q;
            end
            if (configure_tlast) begin
                cfg_cnt_d = 4'd0;
                cfg_bad_d = 1'b0;
                if (cfg_bad_q) begin
                    // Error already reported when the overrun was seen.
                    cfg_state_d  = UNCONF;
                    configured_d = 1'b0;
                end else if (cfg_cnt_q != CFG_LAST_BYTE) begin
                    cfg_err_s    = 1'b1;
                    cfg_state_d  = UNCONF;
                    configured_d = 1'b0;
                end else if (new_qsize_s == 16'd0) begin
                    cfg_err_s    = 1'b1;
                    cfg_state_d  = UNCONF;
                    configured_d = 1'b0;
                end else begin
                    base_d       = shadow_q[63:0];
                    qsize_d      = new_qsize_s;
                    cfg_state_d  = READY;
                    configured_d = 1'b1;
                end
            end else begin
                cfg_state_d = LOAD;
                if (cfg_cnt_q == CFG_LAST_BYTE) begin
                    // Packet too long: report once, then swallow bytes until tlast.
                    cfg_err_s = !cfg_bad_q;
                    cfg_bad_d = 1'b1;
                end else begin
                    cfg_cnt_d = cfg_cnt_q + 4'd1;
                end
            end
        end else begin
            cfg_state_d = cfg_state_q;
        end
    end

    // Request path next state: issue on a good index, hold until tx_tready.
    always_comb begin
        tx_valid_d = tx_valid_q && !tx_tready;
        tx_req_d   = tx_req_q;
        tx_tid_d   = tx_tid_q;
        idx_err_s  = 1'b0;
        if (alloc_s) begin
            tx_valid_d    = 1'b1;
            tx_req_d.addr = desc_addr(base_q, rx_tdata);
            tx_req_d.len  = DESC_SIZE;
            tx_tid_d      = free_tag_s;
        end else begin
            idx_err_s = rx_fire_s;
        end
        error_d = cfg_err_s | idx_err_s | done_err_s;
    end

    // State and output registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cfg_state_q  <= UNCONF;
            cfg_cnt_q    <= 4'd0;
            cfg_bad_q    <= 1'b0;
            shadow_q     <= 72'd0;
            base_q       <= 64'd0;
            qsize_q      <= 16'd0;
            configured_q <= 1'b0;
            error_q      <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_req_q     <= '0;
            tx_tid_q     <= '0;
        end else begin
            cfg_state_q  <= cfg_state_d;
            cfg_cnt_q    <= cfg_cnt_d;
            cfg_bad_q    <= cfg_bad_d;
            shadow_q     <= shadow_d;
            base_q       <= base_d;
            qsize_q      <= qsize_d;
            configured_q <= configured_d;
            error_q      <= error_d;
            tx_valid_q   <= tx_valid_d;
            tx_req_q     <= tx_req_d;
            tx_tid_q     <= tx_tid_d;
        end
    end

    assign tx_tvalid  = tx_valid_q;
    assign tx_tdata   = tx_req_q;
    assign tx_tid     = tx_tid_q;
    assign configured = configured_q;
    assign error      = error_q;

endmodule
